// File: rtl/ccu_window_arbiter.sv
// ccu_window_arbiter
//   Shares one equal-pair counting engine among N_REQ requesters. A requester
//   is granted round-robin, the engine counts cycles with x==y over a window of
//   win_len cycles (0 means 1), then reports the count on z with a done pulse.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req   [N_REQ]     per-requester request, held high for the whole window
//   x_in, y_in        packed operands, requester i at [i*W +: W]
//   win_len [LEN_W]   window length, sampled at grant
//   gnt   [N_REQ]     one-hot grant, zero when idle
//   busy              window active
//   done              one-cycle pulse on normal completion
//   done_id [ID_W]    requester of the last completed window (held)
//   z     [CW]        equal-pair count of the last completed window (held)
//   ovf               only with CCU_SAT_OVF_EN: saturation hit in that window
//
// Optional feature macro: CCU_SAT_OVF_EN (saturating counter plus ovf output).

// Per-lane equality compare; one instance per requester.
module ccu_pair_eq #(
   parameter int W = 3
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         eq
);
   assign eq = (a == b);
endmodule

module ccu_window_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 3,
   parameter int CW    = 8,
   parameter int LEN_W = 4,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] x_in,
   input  logic [N_REQ*W-1:0] y_in,
   input  logic [LEN_W-1:0]   win_len,
   output logic [N_REQ-1:0]   gnt,
   output logic               busy,
   output logic               done,
   output logic [ID_W-1:0]    done_id,
   output logic [CW-1:0]      z
`ifdef CCU_SAT_OVF_EN
   ,
   output logic               ovf
`endif
);

   typedef enum logic {IDLE, COUNT} state_t;

   state_t           state, state_n;
   logic [ID_W-1:0]  last_grant, last_grant_n;
   logic [ID_W-1:0]  gsel, gsel_n;
   logic [LEN_W-1:0] rem, rem_n;
   logic [CW-1:0]    cnt, cnt_n, cnt_inc, z_n;
   logic [N_REQ-1:0] gnt_n;
   logic             busy_n, done_n;
   logic [ID_W-1:0]  done_id_n;
   logic [N_REQ-1:0] eq;
   logic             hit;
   logic             pick_vld;
   logic [ID_W-1:0]  pick_id;
`ifdef CCU_SAT_OVF_EN
   logic             ovf_acc, ovf_acc_n, ovf_n, ovf_hit;
`endif

   for (genvar i = 0; i < N_REQ; i++) begin : g_lane
      ccu_pair_eq #(.W(W)) u_eq (
         .a  (x_in[i*W +: W]),
         .b  (y_in[i*W +: W]),
         .eq (eq[i])
      );
   end

   // Round-robin pick: scan from last_grant+1 upward with wrap. The loop runs
   // from the farthest candidate down so the nearest requester wins.
   always_comb begin : pick_p
      int idx;
      idx      = 0;
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = (int'(last_grant) + k) % N_REQ;
         if (req[idx]) begin
            pick_vld = 1'b1;
            pick_id  = ID_W'(idx);
         end
      end
   end

   assign hit = eq[gsel];

`ifdef CCU_SAT_OVF_EN
   assign ovf_hit = hit && (&cnt);
   assign cnt_inc = (hit && !(&cnt)) ? cnt + 1'b1 : cnt;
`else
   assign cnt_inc = cnt + {{(CW-1){1'b0}}, hit};
`endif

   always_comb begin
      state_n      = state;
      last_grant_n = last_grant;
      gsel_n       = gsel;
      rem_n        = rem;
      cnt_n        = cnt;
      gnt_n        = gnt;
      busy_n       = busy;
      done_n       = 1'b0;
      done_id_n    = done_id;
      z_n          = z;
`ifdef CCU_SAT_OVF_EN
      ovf_acc_n    = ovf_acc;
      ovf_n        = ovf;
`endif
      case (state)
         IDLE: begin
            if (pick_vld) begin
               gsel_n       = pick_id;
               last_grant_n = pick_id;
               gnt_n        = {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
               busy_n       = 1'b1;
               rem_n        = (win_len == '0) ? LEN_W'(1) : win_len;
               cnt_n        = '0;
`ifdef CCU_SAT_OVF_EN
               ovf_acc_n    = 1'b0;
`endif
               state_n      = COUNT;
            end
         end
         COUNT: begin
            if (!req[gsel]) begin
               // Abort: drop the sample, no result; pointer already moved past gsel.
               gnt_n   = '0;
               busy_n  = 1'b0;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (rem == LEN_W'(1)) begin
               cnt_n     = cnt_inc;
               z_n       = cnt_inc;
               done_n    = 1'b1;
               done_id_n = gsel;
               gnt_n     = '0;
               busy_n    = 1'b0;
`ifdef CCU_SAT_OVF_EN
               ovf_n     = ovf_acc | ovf_hit;
`endif
               state_n   = IDLE;
            end else begin
               cnt_n = cnt_inc;
               rem_n = rem - 1'b1;
`ifdef CCU_SAT_OVF_EN
               ovf_acc_n = ovf_acc | ovf_hit;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= ID_W'(N_REQ - 1);  // requester 0 is searched first
         gsel       <= '0;
         rem        <= '0;
         cnt        <= '0;
         gnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         done_id    <= '0;
         z          <= '0;
`ifdef CCU_SAT_OVF_EN
         ovf_acc    <= 1'b0;
         ovf        <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         last_grant <= last_grant_n;
         gsel       <= gsel_n;
         rem        <= rem_n;
         cnt        <= cnt_n;
         gnt        <= gnt_n;
         busy       <= busy_n;
         done       <= done_n;
         done_id    <= done_id_n;
         z          <= z_n;
`ifdef CCU_SAT_OVF_EN
         ovf_acc    <= ovf_acc_n;
         ovf        <= ovf_n;
`endif
      end
   end

endmodule

// File: tb/tb_ccu_window_arbiter.sv
// Testbench for ccu_window_arbiter. A second instance with CW=2 shares the
// stimulus to exercise counter wrap / saturation.
module tb_ccu_window_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [11:0] x_in, y_in;
   logic [3:0]  win_len;
   logic [3:0]  gnt, gnt2;
   logic        busy, busy2, done, done2;
   logic [1:0]  done_id, done_id2;
   logic [7:0]  z;
   logic [1:0]  z2;
`ifdef CCU_SAT_OVF_EN
   logic        ovf, ovf2;
`endif

   int checks = 0;
   int failures = 0;

   // reference model state (transaction level)
   int last_w;
   int exp_z, exp_id;
   int exp_z2;
   bit exp_ovf, exp_ovf2;

   always #5 clk = ~clk;

   ccu_window_arbiter dut (
      .clk(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
      .win_len(win_len), .gnt(gnt), .busy(busy), .done(done),
      .done_id(done_id), .z(z)
`ifdef CCU_SAT_OVF_EN
      , .ovf(ovf)
`endif
   );

   ccu_window_arbiter #(.CW(2)) dut2 (
      .clk(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
      .win_len(win_len), .gnt(gnt2), .busy(busy2), .done(done2),
      .done_id(done_id2), .z(z2)
`ifdef CCU_SAT_OVF_EN
      , .ovf(ovf2)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // First requester with req set, scanning upward from last+1 with wrap.
   function automatic int pick_next(input logic [3:0] r, input int last);
      for (int k = 1; k <= 4; k++)
         if (r[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction

   task automatic apply_reset;
      reset = 1'b1;
      req   = 4'hF;
      x_in  = 12'($urandom);
      y_in  = 12'($urandom);
      win_len = 4'd3;
      tick;
      tick;
      reset = 1'b0;
      req   = 4'h0;
      last_w = 3;
      exp_z = 0; exp_id = 0; exp_z2 = 0; exp_ovf = 0; exp_ovf2 = 0;
   endtask

   // One complete window. Caller sets req (winner predicted here) and must be
   // at an edge where the arbiter is idle. mode 1 forces the winner's pairs
   // from eqmask (bit k = sample k equal); mode 0 is fully random and also
   // toggles non-granted requests and win_len during the window.
   task automatic do_window(input int len_raw, input int mode, input logic [15:0] eqmask);
      int w, L, n;
      logic [3:0] eg;
      logic [2:0] xv, yv;
      w  = pick_next(req, last_w);
      L  = (len_raw == 0) ? 1 : len_raw;
      eg = 4'b0001 << w;
      n  = 0;
      win_len = 4'(len_raw);
      tick;
      checks++;
      if ({gnt, busy, done} !== {eg, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL grant: gnt/busy/done=%b/%b/%b want %b/1/0", gnt, busy, done, eg);
      end
      win_len = 4'($urandom);
      for (int k = 0; k < L; k++) begin
         x_in = 12'($urandom);
         y_in = 12'($urandom);
         xv = x_in[w*3 +: 3];
         if (mode == 1) yv = eqmask[k] ? xv : (xv ^ 3'd1);
         else           yv = $urandom_range(0, 1) ? xv : 3'($urandom);
         y_in[w*3 +: 3] = yv;
         if (xv == yv) n++;
         if (mode == 0) req = 4'($urandom) | eg;
         tick;
         if (k < L - 1) begin
            checks++;
            if ({gnt, busy, done} !== {eg, 1'b1, 1'b0}) begin
               failures++;
               $display("FAIL window_hold: gnt/busy/done=%b/%b/%b want %b/1/0", gnt, busy, done, eg);
            end
         end
      end
`ifdef CCU_SAT_OVF_EN
      exp_z    = (n > 255) ? 255 : n;
      exp_z2   = (n > 3) ? 3 : n;
      exp_ovf  = (n > 255);
      exp_ovf2 = (n > 3);
`else
      exp_z  = n % 256;
      exp_z2 = n % 4;
`endif
      exp_id = w;
      last_w = w;
      checks++;
      if ({gnt, busy, done, done_id} !== {4'b0, 1'b0, 1'b1, 2'(w)}) begin
         failures++;
         $display("FAIL done: gnt/busy/done/id=%b/%b/%b/%0d want 0000/0/1/%0d", gnt, busy, done, done_id, w);
      end
      checks++;
      if (z !== 8'(exp_z)) begin
         failures++;
         $display("FAIL z: got %0d want %0d", z, exp_z);
      end
      checks++;
      if ({done2, z2} !== {1'b1, 2'(exp_z2)}) begin
         failures++;
         $display("FAIL z_cw2: done2/z2=%b/%0d want 1/%0d", done2, z2, exp_z2);
      end
`ifdef CCU_SAT_OVF_EN
      checks++;
      if ({ovf, ovf2} !== {exp_ovf, exp_ovf2}) begin
         failures++;
         $display("FAIL ovf: ovf/ovf2=%b/%b want %b/%b", ovf, ovf2, exp_ovf, exp_ovf2);
      end
`endif
   endtask

   task automatic test_reset;
      apply_reset;
      checks++;
      if ({gnt, busy, done, done_id, z} !== 16'h0) begin
         failures++;
         $display("FAIL reset: gnt/busy/done/id/z=%b/%b/%b/%0d/%0d want all 0", gnt, busy, done, done_id, z);
      end
      checks++;
      if ({gnt2, busy2, done2, done_id2, z2} !== 10'h0) begin
         failures++;
         $display("FAIL reset_cw2: got %b want 0", {gnt2, busy2, done2, done_id2, z2});
      end
   endtask

   task automatic test_single;
      req = 4'b0001;
      do_window(4, 1, 16'h000B);
      req = 4'b0000;
      tick;
      checks++;
      if ({gnt, busy, done, done_id, z} !== {4'b0, 1'b0, 1'b0, 2'd0, 8'd3}) begin
         failures++;
         $display("FAIL single_after: gnt/busy/done/id/z=%b/%b/%b/%0d/%0d want 0/0/0/0/3", gnt, busy, done, done_id, z);
      end
   endtask

   task automatic test_fairness;
      apply_reset;
      req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         do_window(2, 1, 16'hFFFF);
         checks++;
         if ({done_id, z} !== {((i % 2) ? 2'd2 : 2'd0), 8'd2}) begin
            failures++;
            $display("FAIL fairness_%0d: id/z=%0d/%0d want %0d/2", i, done_id, z, (i % 2) ? 2 : 0);
         end
      end
      req = 4'b0000;
      tick;
      checks++;
      if ({gnt, done} !== 5'b0) begin
         failures++;
         $display("FAIL fairness_idle: gnt/done=%b/%b want 0/0", gnt, done);
      end
   endtask

   task automatic test_zero_len;
      req = 4'b1000;
      do_window(0, 1, 16'h0001);
      checks++;
      if ({done_id, z} !== {2'd3, 8'd1}) begin
         failures++;
         $display("FAIL zero_len: id/z=%0d/%0d want 3/1", done_id, z);
      end
      req = 4'b0000;
      tick;
   endtask

   task automatic test_abort;
      req = 4'b0010;
      win_len = 4'd8;
      tick;
      checks++;
      if (gnt !== 4'b0010) begin
         failures++;
         $display("FAIL abort_grant: gnt=%b want 0010", gnt);
      end
      for (int k = 0; k < 2; k++) begin
         x_in = 12'($urandom);
         y_in = x_in;
         tick;
      end
      req = 4'b0000;
      tick;
      last_w = 1;
      checks++;
      if ({gnt, busy, done, done_id, z} !== {4'b0, 1'b0, 1'b0, 2'(exp_id), 8'(exp_z)}) begin
         failures++;
         $display("FAIL abort: gnt/busy/done/id/z=%b/%b/%b/%0d/%0d want 0/0/0/%0d/%0d", gnt, busy, done, done_id, z, exp_id, exp_z);
      end
      tick;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL abort_nodone: done=%b want 0", done);
      end
      req = 4'b1011;
      do_window(3, 0, 16'h0);
      checks++;
      if (done_id !== 2'd3) begin
         failures++;
         $display("FAIL abort_rr: id=%0d want 3", done_id);
      end
      req = 4'b0000;
      tick;
   endtask

   task automatic test_reset_mid;
      req = 4'b0100;
      win_len = 4'd6;
      tick;
      for (int k = 0; k < 3; k++) begin
         x_in = 12'($urandom);
         y_in = x_in;
         tick;
      end
      reset = 1'b1;
      req = 4'b0110;
      tick;
      reset = 1'b0;
      last_w = 3; exp_z = 0; exp_id = 0; exp_z2 = 0;
      checks++;
      if ({gnt, busy, done, done_id, z} !== 16'h0) begin
         failures++;
         $display("FAIL reset_mid: gnt/busy/done/id/z=%b/%b/%b/%0d/%0d want all 0", gnt, busy, done, done_id, z);
      end
      do_window(5, 1, 16'h001F);
      checks++;
      if (done_id !== 2'd1) begin
         failures++;
         $display("FAIL reset_mid_rr: id=%0d want 1", done_id);
      end
      req = 4'b0000;
      tick;
   endtask

   task automatic test_wrap;
      req = 4'b0100;
      do_window(6, 1, 16'hFFFF);
      checks++;
`ifdef CCU_SAT_OVF_EN
      if ({z, z2, ovf2} !== {8'd6, 2'd3, 1'b1}) begin
         failures++;
         $display("FAIL wrap: z/z2/ovf2=%0d/%0d/%b want 6/3/1", z, z2, ovf2);
      end
`else
      if ({z, z2} !== {8'd6, 2'd2}) begin
         failures++;
         $display("FAIL wrap: z/z2=%0d/%0d want 6/2", z, z2);
      end
`endif
      req = 4'b0000;
      tick;
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 30; i++) begin
         req = 4'($urandom_range(1, 15));
         do_window($urandom_range(0, 15), 0, 16'h0);
      end
      req = 4'b0000;
      tick;
      tick;
      checks++;
      if ({gnt, busy, done} !== 6'b0) begin
         failures++;
         $display("FAIL final_idle: gnt/busy/done=%b/%b/%b want 0/0/0", gnt, busy, done);
      end
   endtask

   initial begin
      reset = 1'b1; req = '0; x_in = '0; y_in = '0; win_len = '0;
      test_reset;
      test_single;
      test_fairness;
      test_zero_len;
      test_abort;
      test_reset_mid;
      test_wrap;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a runaway simulation.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
